// File: rtl/ntt_addr_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | ntt_addr_sched_pkg : opcodes, state encodings and defaults for the scheduler |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package ntt_addr_sched_pkg;

    localparam int DEF_P_SHIFT  = 2;
    localparam int DEF_PIPE_LAT = 6;

    localparam logic [1:0] OP_NTT  = 2'd0;
    localparam logic [1:0] OP_INTT = 2'd1;
    localparam logic [1:0] OP_PWM0 = 2'd2;
    localparam logic [1:0] OP_PWM1 = 2'd3;

    localparam logic [5:0] LAST_STAGE = 6'd6;

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_RUN   = 3'd1,
        SCH_GAP   = 3'd2,
        SCH_DRAIN = 3'd3,
        SCH_DONE  = 3'd4
    } sched_state_t;

    function automatic logic is_pwm(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_addr_sched_timer.sv
// +----------------------------------------------------------------------------+
// | ntt_addr_sched_timer : down-counter loaded with LAT-1, flags expiry at zero |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module ntt_addr_sched_timer #(
    parameter int LAT = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(LAT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= LOAD_VAL;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    // Expiry is seen during the last idle cycle so the caller can leave on that edge.
    assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ntt_addr_sched.sv
// +----------------------------------------------------------------------------+
// | ntt_addr_sched : (i, s) walk sequencer for NTT/INTT/PWM passes with drain    |
// | Optional macro CTRL_HOLD_EN adds the hold port.        Revision 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ntt_addr_sched
    import ntt_addr_sched_pkg::*;
#(
    parameter int P_SHIFT  = DEF_P_SHIFT,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] opcode_in,
`ifdef CTRL_HOLD_EN
    input  logic       hold,
`endif
    output logic [5:0] i,
    output logic [6:0] s,
    output logic [1:0] opcode,
    output logic       issue,
    output logic       stage_end,
    output logic       busy,
    output logic       done
);

    localparam int         NBLK       = 128 >> P_SHIFT;
    localparam logic [6:0] S_STEP     = 7'(1 << P_SHIFT);
    localparam logic [6:0] S_LAST     = 7'(128 - (1 << P_SHIFT));
    localparam logic [5:0] PWM_I_LAST = 6'(NBLK / 2 - 1);

    sched_state_t r_state, w_state;
    logic [5:0]   r_i, w_i;
    logic [6:0]   r_s, w_s;
    logic [1:0]   r_opcode, w_opcode;
    logic         r_issue, w_issue;
    logic         r_stage_end, w_stage_end;
    logic         r_busy, w_busy;
    logic         r_done, w_done;
    logic         r_last, w_last;
    logic         w_tmr_load, w_tmr_en, w_tmr_expired;
    logic         w_more;
    logic         w_hold;

`ifdef CTRL_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    function automatic logic last_of_stage(input logic [1:0] op,
                                           input logic [5:0] ii,
                                           input logic [6:0] ss);
        if (is_pwm(op)) begin
            return (ii == PWM_I_LAST) && (ss == 7'd1);
        end
        return ss == S_LAST;
    endfunction

    assign w_more = ((r_opcode == OP_NTT)  && (r_i != LAST_STAGE)) ||
                    ((r_opcode == OP_INTT) && (r_i != 6'd0));

    ntt_addr_sched_timer #(
        .LAT (PIPE_LAT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_tmr_load),
        .en      (w_tmr_en),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= SCH_IDLE;
            r_i         <= '0;
            r_s         <= '0;
            r_opcode    <= OP_NTT;
            r_issue     <= 1'b0;
            r_stage_end <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_i         <= w_i;
            r_s         <= w_s;
            r_opcode    <= w_opcode;
            r_issue     <= w_issue;
            r_stage_end <= w_stage_end;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_last      <= w_last;
        end
    end

    // r_last remembers whether the most recent issue closed a stage, independent of
    // the stage_end pulse, so a hold can blank the pulse without losing the fact.
    always_comb begin
        w_state     = r_state;
        w_i         = r_i;
        w_s         = r_s;
        w_opcode    = r_opcode;
        w_issue     = 1'b0;
        w_stage_end = 1'b0;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_last      = r_last;
        w_tmr_load  = 1'b0;
        w_tmr_en    = 1'b0;

        if (!w_hold) begin
            case (r_state)
                SCH_IDLE: begin
                    if (start) begin
                        w_opcode    = opcode_in;
                        w_i         = (opcode_in == OP_INTT) ? LAST_STAGE : 6'd0;
                        w_s         = 7'd0;
                        w_last      = last_of_stage(opcode_in, w_i, w_s);
                        w_issue     = 1'b1;
                        w_stage_end = w_last;
                        w_busy      = 1'b1;
                        w_state     = SCH_RUN;
                    end
                end
                SCH_RUN: begin
                    if (r_last) begin
                        w_tmr_load = 1'b1;
                        w_state    = w_more ? SCH_GAP : SCH_DRAIN;
                    end else begin
                        if (is_pwm(r_opcode)) begin
                            if (r_s == 7'd1) begin
                                w_s = 7'd0;
                                w_i = r_i + 6'd1;
                            end else begin
                                w_s = 7'd1;
                            end
                        end else begin
                            w_s = r_s + S_STEP;
                        end
                        w_last      = last_of_stage(r_opcode, w_i, w_s);
                        w_issue     = 1'b1;
                        w_stage_end = w_last;
                    end
                end
                SCH_GAP: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_expired) begin
                        w_i         = (r_opcode == OP_INTT) ? (r_i - 6'd1) : (r_i + 6'd1);
                        w_s         = 7'd0;
                        w_last      = last_of_stage(r_opcode, w_i, w_s);
                        w_issue     = 1'b1;
                        w_stage_end = w_last;
                        w_state     = SCH_RUN;
                    end
                end
                SCH_DRAIN: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_expired) begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = SCH_DONE;
                    end
                end
                SCH_DONE: begin
                    w_state = SCH_IDLE;
                end
                default: begin
                    w_state = SCH_IDLE;
                    w_busy  = 1'b0;
                end
            endcase
        end
    end

    assign i         = r_i;
    assign s         = r_s;
    assign opcode    = r_opcode;
    assign issue     = r_issue;
    assign stage_end = r_stage_end;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ntt_addr_sched.sv
// +----------------------------------------------------------------------------+
// | tb_ntt_addr_sched : scoreboard bench for ntt_addr_sched (P_SHIFT=2, LAT=6)   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ntt_addr_sched;
    import ntt_addr_sched_pkg::*;

    localparam int P_SHIFT  = 2;
    localparam int PIPE_LAT = 6;
    localparam int NBLK     = 128 >> P_SHIFT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] opcode_in = 2'd0;
    logic       hold = 1'b0;
    logic [5:0] i;
    logic [6:0] s;
    logic [1:0] opcode;
    logic       issue;
    logic       stage_end;
    logic       busy;
    logic       done;

    ntt_addr_sched #(
        .P_SHIFT  (P_SHIFT),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode_in (opcode_in),
`ifdef CTRL_HOLD_EN
        .hold      (hold),
`endif
        .i         (i),
        .s         (s),
        .opcode    (opcode),
        .issue     (issue),
        .stage_end (stage_end),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] i;
        logic [6:0] s;
        logic       se;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_pass(input logic [1:0] op);
        exp_t e;
        if (op == OP_NTT || op == OP_INTT) begin
            for (int st = 0; st < 7; st++) begin
                for (int b = 0; b < NBLK; b++) begin
                    e.op = op;
                    e.i  = (op == OP_INTT) ? 6'(6 - st) : 6'(st);
                    e.s  = 7'(b << P_SHIFT);
                    e.se = (b == NBLK - 1);
                    q.push_back(e);
                end
            end
        end else begin
            for (int r = 0; r < NBLK / 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    e.op = op;
                    e.i  = 6'(r);
                    e.s  = 7'(c);
                    e.se = (r == NBLK / 2 - 1) && (c == 1);
                    q.push_back(e);
                end
            end
        end
    endtask

    // k = 0 is the first cycle after the start-accepting edge; done lands at
    // k = issues + idle cycles (268 / 40 cycles start->done inclusive).
    task automatic run_pass(input logic [1:0] op, input int inject, input int abort_at,
                            input int hold_at, input int hold_len);
        int   k;
        int   nissue;
        int   gap;
        int   exp_done;
        int   exp_issues;
        bit   seen_done;
        exp_t e;
        q.delete();
        push_pass(op);
        exp_issues = q.size();
        exp_done   = ((op == OP_NTT || op == OP_INTT) ? 7 * (NBLK + PIPE_LAT)
                                                      : NBLK + PIPE_LAT) + hold_len;
        k = 0; nissue = 0; gap = 0; seen_done = 0;
        @(negedge clk);
        start = 1'b1; opcode_in = op;
        @(negedge clk);
        while (k < 3000 && !seen_done) begin
            start = 1'b0;
            opcode_in = ~op;
            if (!rst) begin
                check("abort_idle", 32'({issue, stage_end, busy, done}), 32'd0);
                check("abort_is", 32'({i, s}), 32'd0);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                check("abort_no_done", 32'({issue, busy, done}), 32'd0);
                return;
            end
            if (k == 0) check("busy_first", 32'(busy), 32'd1);
            if (issue) begin
                if (gap != 0 && hold_len == 0) check("gap_len", 32'(gap), 32'(PIPE_LAT));
                gap = 0;
                if (q.size() == 0) begin
                    check("issue_count", 32'(nissue + 1), 32'(exp_issues));
                end else begin
                    e = q.pop_front();
                    check("issue", 32'({opcode, i, s, stage_end}), 32'(e));
                end
                nissue++;
                if (nissue == abort_at) rst = 1'b0;
            end else if (busy) begin
                gap++;
            end
            if (done) begin
                seen_done = 1;
                check("done_cycle", 32'(k), 32'(exp_done));
                check("busy_at_done", 32'(busy), 32'd0);
                check("left_in_queue", 32'(q.size()), 32'd0);
                if (inject != 0) begin
                    start = 1'b1;
                    opcode_in = OP_PWM1;
                end
            end
            if (inject != 0 && k == 50) begin
                start = 1'b1;
                opcode_in = OP_PWM0;
            end
            if (hold_len != 0 && k == hold_at) hold = 1'b1;
            if (hold_len != 0 && k == hold_at + hold_len) hold = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!seen_done) check("done_timeout", 32'(k), 32'(exp_done));
        if (inject != 0) begin
            check("start_in_done_ignored", 32'({issue, busy}), 32'd0);
            @(negedge clk);
            check("still_idle", 32'({issue, busy, done}), 32'd0);
            check("opcode_latched", 32'(opcode), 32'(op));
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b1;
        opcode_in = OP_PWM1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_outputs", 32'({i, s, opcode, issue, stage_end, busy, done}), 32'd0);
        end
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'({issue, busy, done}), 32'd0);

        run_pass(OP_NTT, 0, 0, 0, 0);
        run_pass(OP_INTT, 0, 0, 0, 0);
        run_pass(OP_PWM1, 0, 0, 0, 0);
        run_pass(OP_PWM0, 0, 0, 0, 0);
        run_pass(OP_NTT, 1, 0, 0, 0);
        run_pass(OP_NTT, 0, 100, 0, 0);
        run_pass(OP_NTT, 0, 0, 0, 0);
`ifdef CTRL_HOLD_EN
        run_pass(OP_NTT, 0, 0, 34, 10);
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
